// File: rtl/display_scan_pkg.sv
// Shared constants and helpers for the four-digit display scanner.
package display_scan_pkg;

  localparam int          NDIG      = 4;
  localparam logic [3:0]  AN_OFF    = 4'b1111;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [1:0]  SLOT_WRAP = 2'd3;

  // Slot order 3 -> 0 -> 1 -> 2 -> 3: field [2k+1:2k] holds the slot that follows slot k.
  localparam logic [7:0]  SLOT_NEXT = {2'd0, 2'd3, 2'd2, 2'd1};

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return SLOT_NEXT[{s, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] digit_at(input logic [15:0] v, input logic [1:0] n);
    return v[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] onehot_low(input logic [1:0] n);
    return ~(4'b0001 << n);
  endfunction

  // True when any of the four digits holds a non-BCD code.
  function automatic logic has_bad_digit(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (digit_at(v, 2'(k)) > BCD_MAX) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // True when slot n is a leading zero: n is not the units digit and digits n..3 are all zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] n);
    logic all_zero;
    all_zero = (n != 2'd0);
    for (int k = 0; k < NDIG; k++) begin
      if ((k >= int'(n)) && (digit_at(v, 2'(k)) != 4'h0)) begin
        all_zero = 1'b0;
      end else begin
        all_zero = all_zero;
      end
    end
    return all_zero;
  endfunction

endpackage

// File: rtl/display_scan_tick.sv
// Prescaler: counts 0..SCAN_DIV-1 and flags the last count of each digit slot.
module scan_tick #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running slot counter, wraps after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner. Drives a BCD code and active-low
// anodes to an external seven-segment decoder, with double-buffered updates,
// optional leading-zero suppression and blanking of non-BCD codes.
module display_scan
  import display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        err
);

  logic        tick;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [15:0] active;
  logic        pending;

  logic        wrap;
  logic        commit;
  logic [15:0] active_next;
  logic [1:0]  slot;
  logic [3:0]  code;
  logic        blank;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Frame wrap, commit decision and the code/blanking for the slot about to be shown.
  always_comb begin
    wrap        = tick && (idx == SLOT_WRAP);
    commit      = wrap && pending;
    active_next = commit ? shadow : active;
    slot        = next_slot(idx);
    code        = digit_at(active_next, slot);
    blank       = (code > BCD_MAX) || (blank_lz && lz_blank(active_next, slot));
  end

  // Slot index advances once per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= SLOT_WRAP;
    end else if (tick) begin
      idx <= slot;
    end else begin
      idx <= idx;
    end
  end

  // Shadow capture; a load on the wrap tick keeps pending so it commits next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= din;
      pending <= 1'b1;
    end else if (commit) begin
      shadow  <= shadow;
      pending <= 1'b0;
    end else begin
      shadow  <= shadow;
      pending <= pending;
    end
  end

  // Active value and error flag update only at a frame-wrap commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 16'h0000;
      err    <= 1'b0;
    end else if (commit) begin
      active <= shadow;
      err    <= has_bad_digit(shadow);
    end else begin
      active <= active;
      err    <= err;
    end
  end

  // Output registers load on the tick edge and hold for the whole slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit      <= 4'h0;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        if (blank) begin
          digit <= 4'h0;
          an    <= AN_OFF;
        end else begin
          digit <= code;
          an    <= onehot_low(slot);
        end
      end else begin
        digit <= digit;
        an    <= an;
      end
    end
  end

endmodule
